// File: rtl/qracc_sram_ctrl.sv
// SRAM access controller: sequences PCH/WL/WRITE/CSEL/SAEN for one access at a time.
// Optional per-column write mask is enabled with `define QRACC_SRAM_WMASK_EN.
module qracc_sram_ctrl #(
  parameter int NUM_ROWS = 128,
  parameter int NUM_COLS = 32,
  parameter int CFG_W    = 4
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        rq_wr_i,
  input  logic                        rq_valid_i,
  output logic                        rq_ready_o,
  output logic                        rd_valid_o,
  output logic [NUM_COLS-1:0]         rd_data_o,
  input  logic [NUM_COLS-1:0]         wr_data_i,
`ifdef QRACC_SRAM_WMASK_EN
  input  logic [NUM_COLS-1:0]         wr_mask_i,
`endif
  input  logic [$clog2(NUM_ROWS)-1:0] addr_i,
  input  logic [CFG_W-1:0]            cfg_pch_cycles_i,
  input  logic [CFG_W-1:0]            cfg_wl_cycles_i,
  output logic [NUM_ROWS-1:0]         wl_o,
  output logic                        pch_o,
  output logic                        write_o,
  output logic [NUM_COLS-1:0]         wr_data_o,
  output logic [NUM_COLS-1:0]         csel_o,
  output logic                        saen_o,
  input  logic [NUM_COLS-1:0]         sa_out_i,
  output logic                        busy_o
);

  // state | meaning
  // IDLE  | ready for a request
  // PCH   | bitline precharge, P cycles
  // WL    | wordline (and write drive) pulse, W cycles
  // SENSE | sense-amp enable, SA_OUT captured at end of cycle
  // DONE  | recovery gap, read data valid for reads
  typedef enum logic [2:0] {S_IDLE, S_PCH, S_WL, S_SENSE, S_DONE} state_t;

  localparam int AW = $clog2(NUM_ROWS);

  state_t                state_q, state_d;
  logic [CFG_W-1:0]      cnt_q, cnt_d;
  logic [CFG_W-1:0]      wl_len_q, wl_len_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [NUM_COLS-1:0]   wdata_q, wdata_d;
  logic [NUM_COLS-1:0]   wr_csel;
  logic [NUM_ROWS-1:0]   wl_q, wl_d;
  logic                  pch_q, pch_d;
  logic                  write_q, write_d;
  logic [NUM_COLS-1:0]   wr_data_q, wr_data_d;
  logic [NUM_COLS-1:0]   csel_q, csel_d;
  logic                  saen_q, saen_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [NUM_COLS-1:0]   rd_data_q, rd_data_d;
  logic [CFG_W-1:0]      pch_eff, wl_eff;
  logic                  row_ok;
  logic [NUM_ROWS-1:0]   wl_vec;

`ifdef QRACC_SRAM_WMASK_EN
  logic [NUM_COLS-1:0]   mask_q, mask_d;
  assign wr_csel = mask_q;
`else
  assign wr_csel = '1;
`endif

  assign rq_ready_o = (state_q == S_IDLE);
  assign busy_o     = (state_q != S_IDLE);

  always_comb begin
    pch_eff = (cfg_pch_cycles_i == '0) ? CFG_W'(1) : cfg_pch_cycles_i;
    wl_eff  = (cfg_wl_cycles_i  == '0) ? CFG_W'(1) : cfg_wl_cycles_i;
    // Rows at or beyond NUM_ROWS run the full sequence with no wordline.
    row_ok  = ({1'b0, addr_q} < (AW+1)'(NUM_ROWS));
    wl_vec  = '0;
    if (row_ok) wl_vec[addr_q] = 1'b1;

    state_d   = state_q;
    cnt_d     = cnt_q;
    wl_len_d  = wl_len_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
`ifdef QRACC_SRAM_WMASK_EN
    mask_d    = mask_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (rq_valid_i) begin
          state_d  = S_PCH;
          cnt_d    = pch_eff - CFG_W'(1);
          wl_len_d = wl_eff;
          addr_d   = addr_i;
          wr_d     = rq_wr_i;
          wdata_d  = wr_data_i;
`ifdef QRACC_SRAM_WMASK_EN
          mask_d   = wr_mask_i;
`endif
        end
      end
      S_PCH: begin
        if (cnt_q == '0) begin
          state_d = S_WL;
          cnt_d   = wl_len_q - CFG_W'(1);
        end else begin
          cnt_d = cnt_q - CFG_W'(1);
        end
      end
      S_WL: begin
        if (cnt_q == '0) state_d = wr_q ? S_DONE : S_SENSE;
        else             cnt_d   = cnt_q - CFG_W'(1);
      end
      S_SENSE: begin
        state_d   = S_DONE;
        rd_data_d = row_ok ? sa_out_i : '0;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state.
    pch_d      = (state_d == S_PCH);
    wl_d       = (state_d == S_WL || state_d == S_SENSE) ? wl_vec : '0;
    write_d    = (state_d == S_WL) && wr_q;
    wr_data_d  = ((state_d == S_WL) && wr_q) ? wdata_q : '0;
    csel_d     = (state_d == S_WL) ? (wr_q ? wr_csel : '1) : '0;
    saen_d     = (state_d == S_SENSE);
    rd_valid_d = (state_d == S_DONE) && !wr_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wl_len_q   <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      wl_q       <= '0;
      pch_q      <= 1'b0;
      write_q    <= 1'b0;
      wr_data_q  <= '0;
      csel_q     <= '0;
      saen_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
`ifdef QRACC_SRAM_WMASK_EN
      mask_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wl_len_q   <= wl_len_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      wl_q       <= wl_d;
      pch_q      <= pch_d;
      write_q    <= write_d;
      wr_data_q  <= wr_data_d;
      csel_q     <= csel_d;
      saen_q     <= saen_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
`ifdef QRACC_SRAM_WMASK_EN
      mask_q     <= mask_d;
`endif
    end
  end

  assign wl_o       = wl_q;
  assign pch_o      = pch_q;
  assign write_o    = write_q;
  assign wr_data_o  = wr_data_q;
  assign csel_o     = csel_q;
  assign saen_o     = saen_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_qracc_sram_ctrl.sv
// Directed bench for qracc_sram_ctrl: a 128-row instance and a 100-row instance share stimulus.
module tb_qracc_sram_ctrl;
  logic        clk = 1'b0;
  logic        nrst;
  logic        rq_wr, rq_valid;
  logic [31:0] wr_data;
  logic [31:0] wr_mask;
  logic [6:0]  addr;
  logic [3:0]  cfg_pch, cfg_wl;

  logic         ready_a, rdv_a, pch_a, write_a, saen_a, busy_a;
  logic [31:0]  rdd_a, wrd_a, csel_a, sa_a;
  logic [127:0] wl_a;
  logic         ready_b, rdv_b, pch_b, write_b, saen_b, busy_b;
  logic [31:0]  rdd_b, wrd_b, csel_b, sa_b;
  logic [99:0]  wl_b;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  qracc_sram_ctrl #(.NUM_ROWS(128), .NUM_COLS(32), .CFG_W(4)) dut (
    .clk(clk), .nrst(nrst), .rq_wr_i(rq_wr), .rq_valid_i(rq_valid), .rq_ready_o(ready_a),
    .rd_valid_o(rdv_a), .rd_data_o(rdd_a), .wr_data_i(wr_data),
`ifdef QRACC_SRAM_WMASK_EN
    .wr_mask_i(wr_mask),
`endif
    .addr_i(addr), .cfg_pch_cycles_i(cfg_pch), .cfg_wl_cycles_i(cfg_wl),
    .wl_o(wl_a), .pch_o(pch_a), .write_o(write_a), .wr_data_o(wrd_a), .csel_o(csel_a),
    .saen_o(saen_a), .sa_out_i(sa_a), .busy_o(busy_a));

  qracc_sram_ctrl #(.NUM_ROWS(100), .NUM_COLS(32), .CFG_W(4)) dut100 (
    .clk(clk), .nrst(nrst), .rq_wr_i(rq_wr), .rq_valid_i(rq_valid), .rq_ready_o(ready_b),
    .rd_valid_o(rdv_b), .rd_data_o(rdd_b), .wr_data_i(wr_data),
`ifdef QRACC_SRAM_WMASK_EN
    .wr_mask_i(wr_mask),
`endif
    .addr_i(addr), .cfg_pch_cycles_i(cfg_pch), .cfg_wl_cycles_i(cfg_wl),
    .wl_o(wl_b), .pch_o(pch_b), .write_o(write_b), .wr_data_o(wrd_b), .csel_o(csel_b),
    .saen_o(saen_b), .sa_out_i(sa_b), .busy_o(busy_b));

  // Array model: rows preset to C0DE_0000|row, written through WL/WRITE/CSEL of the 128-row instance.
  logic [31:0] mem [128];
  bit          mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
      mem_init <= 1'b1;
    end else if (write_a) begin
      for (int i = 0; i < 128; i++)
        if (wl_a[i]) mem[i] <= (mem[i] & ~csel_a) | (wrd_a & csel_a);
    end
  end

  always_comb begin
    sa_a = '0;
    if (saen_a)
      for (int i = 0; i < 128; i++) if (wl_a[i]) sa_a = mem[i];
    sa_b = '0;
    if (saen_b) begin
      sa_b = 32'hDEAD_BEEF;
      for (int i = 0; i < 100; i++) if (wl_b[i]) sa_b = mem[i];
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (nrst === 1'b1) begin
      chk("wl_onehot", {127'd0, $onehot0(wl_a)}, 128'd1);
      chk("pch_excl", {127'd0, !(pch_a && (|wl_a || saen_a))}, 128'd1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge with the controller idle; returns in cycle t+1.
  task automatic issue(input logic wr, input logic [6:0] a, input logic [31:0] d,
                       input logic [31:0] m, input logic [3:0] p, input logic [3:0] w);
    rq_wr = wr; addr = a; wr_data = d; wr_mask = m; cfg_pch = p; cfg_wl = w;
    rq_valid = 1'b1;
    step();
    rq_valid = 1'b0;
  endtask

  initial begin
    bit seen;
    nrst = 1'b0; rq_wr = 1'b0; rq_valid = 1'b0; wr_data = '0; wr_mask = '1;
    addr = '0; cfg_pch = 4'd1; cfg_wl = 4'd1;
    #3;
    chk("rst_ready", {127'd0, ready_a}, 128'd1);
    chk("rst_busy", {127'd0, busy_a}, 128'd0);
    chk("rst_wl", wl_a, 128'd0);
    chk("rst_ctl", {124'd0, pch_a, write_a, saen_a, rdv_a}, 128'd0);
    chk("rst_rdd", {96'd0, rdd_a}, 128'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) nrst = 1'b1;
    step();

    // Write row 5, P=2 W=2
    issue(1'b1, 7'd5, 32'hA5A5_1234, 32'hFFFF_FFFF, 4'd2, 4'd2);
    chk("w_t1_pch", {126'd0, pch_a, busy_a}, 128'd3);
    chk("w_t1_ready", {127'd0, ready_a}, 128'd0);
    step();
    chk("w_t2_pch", {127'd0, pch_a}, 128'd1);
    chk("w_t2_wl", wl_a, 128'd0);
    step();
    chk("w_t3_wl", wl_a, 128'd1 << 5);
    chk("w_t3_ctl", {126'd0, pch_a, write_a}, 128'd1);
    chk("w_t3_wrd", {96'd0, wrd_a}, {96'd0, 32'hA5A5_1234});
    chk("w_t3_csel", {96'd0, csel_a}, {96'd0, 32'hFFFF_FFFF});
    step();
    chk("w_t4_wl", wl_a, 128'd1 << 5);
    chk("w_t4_write", {127'd0, write_a}, 128'd1);
    step();
    chk("w_t5_wl", wl_a, 128'd0);
    chk("w_t5_ctl", {124'd0, write_a, rdv_a, ready_a, busy_a}, 128'd1);
    chk("w_t5_bus", {64'd0, wrd_a, csel_a}, 128'd0);
    step();
    chk("w_t6_ready", {127'd0, ready_a}, 128'd1);

    // Read row 5, P=2 W=2
    issue(1'b0, 7'd5, 32'h0, 32'hFFFF_FFFF, 4'd2, 4'd2);
    step(); step();
    chk("r_t3_wl", wl_a, 128'd1 << 5);
    chk("r_t3_write", {127'd0, write_a}, 128'd0);
    chk("r_t3_csel", {96'd0, csel_a}, {96'd0, 32'hFFFF_FFFF});
    step(); step();
    chk("r_t5_sense", {125'd0, saen_a, pch_a, rdv_a}, 128'd4);
    chk("r_t5_wl", wl_a, 128'd1 << 5);
    step();
    chk("r_t6_valid", {126'd0, rdv_a, saen_a}, 128'd2);
    chk("r_t6_data", {96'd0, rdd_a}, {96'd0, 32'hA5A5_1234});
    chk("r_t6_wl", wl_a, 128'd0);
    step();
    chk("r_t7_valid", {126'd0, rdv_a, ready_a}, 128'd1);
    chk("r_t7_hold", {96'd0, rdd_a}, {96'd0, 32'hA5A5_1234});

    // P=0 W=0 behave as 1; cfg changed mid-access is ignored
    issue(1'b0, 7'd5, 32'h0, 32'hFFFF_FFFF, 4'd0, 4'd0);
    cfg_pch = 4'd7; cfg_wl = 4'd7;
    chk("z_t1_pch", {127'd0, pch_a}, 128'd1);
    step();
    chk("z_t2_wl", wl_a, 128'd1 << 5);
    chk("z_t2_pch", {127'd0, pch_a}, 128'd0);
    step();
    chk("z_t3_saen", {127'd0, saen_a}, 128'd1);
    step();
    chk("z_t4_valid", {127'd0, rdv_a}, 128'd1);
    chk("z_t4_data", {96'd0, rdd_a}, {96'd0, 32'hA5A5_1234});
    step();
    chk("z_t5_ready", {127'd0, ready_a}, 128'd1);

    // Last row write and read back
    issue(1'b1, 7'd127, 32'h1357_9BDF, 32'hFFFF_FFFF, 4'd1, 4'd1);
    step();
    chk("l_wl127", wl_a, 128'd1 << 127);
    chk("l_wl_oor", {28'd0, wl_b}, 128'd0);
    step(); step();
    chk("l_ready", {127'd0, ready_a}, 128'd1);
    issue(1'b0, 7'd127, 32'h0, 32'hFFFF_FFFF, 4'd1, 4'd1);
    step(); step(); step();
    chk("l_rd_valid", {126'd0, rdv_a, rdv_b}, 128'd3);
    chk("l_rd_data", {96'd0, rdd_a}, {96'd0, 32'h1357_9BDF});
    step();

    // Row 100: valid for 128 rows, out of range for 100 rows
    issue(1'b0, 7'd100, 32'h0, 32'hFFFF_FFFF, 4'd1, 4'd1);
    step();
    chk("o_wl_a", wl_a, 128'd1 << 100);
    chk("o_wl_b", {28'd0, wl_b}, 128'd0);
    step();
    chk("o_saen_b", {126'd0, saen_b, saen_a}, 128'd3);
    step();
    chk("o_valid", {126'd0, rdv_a, rdv_b}, 128'd3);
    chk("o_data_a", {96'd0, rdd_a}, {96'd0, 32'hC0DE_0064});
    chk("o_data_b", {96'd0, rdd_b}, 128'd0);
    step();
    chk("o_ready_b", {127'd0, ready_b}, 128'd1);

`ifdef QRACC_SRAM_WMASK_EN
    issue(1'b1, 7'd9, 32'hFFFF_FFFF, 32'h0000_FFFF, 4'd1, 4'd1);
    step();
    chk("m_csel_w", {96'd0, csel_a}, {96'd0, 32'h0000_FFFF});
    step(); step();
    issue(1'b0, 7'd9, 32'h0, 32'h0000_FFFF, 4'd1, 4'd1);
    step();
    chk("m_csel_r", {96'd0, csel_a}, {96'd0, 32'hFFFF_FFFF});
    step(); step();
    chk("m_data", {96'd0, rdd_a}, {96'd0, 32'hC0DE_FFFF});
    step();
`endif

    // Reset during SENSE
    issue(1'b0, 7'd5, 32'h0, 32'hFFFF_FFFF, 4'd1, 4'd1);
    step(); step();
    chk("x_saen_pre", {127'd0, saen_a}, 128'd1);
    nrst = 1'b0;
    #1;
    chk("x_ctl", {125'd0, saen_a, pch_a, rdv_a}, 128'd0);
    chk("x_wl", wl_a, 128'd0);
    chk("x_ready", {127'd0, ready_a}, 128'd1);
    @(negedge clk);
    @(negedge clk) nrst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (rdv_a) seen = 1'b1;
    end
    chk("x_no_valid", {127'd0, seen}, 128'd0);
    chk("x_ready_post", {127'd0, ready_a}, 128'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/qracc_sram_ctrl.md
Name: qracc_sram_ctrl

Overview:
- Parametrised SRAM access controller implementing the slave side of the digital SRAM request interface.
- Sequences the analog array's SRAM control pins: WL, PCH, WRITE, WR_DATA, CSEL and SAEN.
- Captures SA_OUT from the array and returns it as read data.
- Successor to the fixed 128x32 access path: generic in rows and columns, with runtime-programmable precharge and wordline pulse widths and an optional per-column write mask.

Parameters:
- NUM_ROWS, 128, number of wordlines; need not be a power of two.
- NUM_COLS, 32, data width and number of bitline columns.
- CFG_W, 4, width of the timing configuration fields.

Ports:
- clk  in  1  system clock.
- nrst  in  1  asynchronous active-low reset.
- rq_wr_i  in  1  1 = write request, 0 = read request.
- rq_valid_i  in  1  request valid.
- rq_ready_o  out  1  controller can accept a request.
- rd_valid_o  out  1  one-cycle pulse; rd_data_o is valid.
- rd_data_o  out  NUM_COLS  read data.
- wr_data_i  in  NUM_COLS  write data.
- addr_i  in  $clog2(NUM_ROWS)  row address.
- cfg_pch_cycles_i  in  CFG_W  precharge pulse length in cycles.
- cfg_wl_cycles_i  in  CFG_W  wordline/write pulse length in cycles.
- wl_o  out  NUM_ROWS  one-hot wordline drive (to WL).
- pch_o  out  1  bitline precharge (to PCH).
- write_o  out  1  write enable (to WRITE).
- wr_data_o  out  NUM_COLS  bitline write data (to WR_DATA).
- csel_o  out  NUM_COLS  column select (to CSEL).
- saen_o  out  1  sense-amp enable (to SAEN).
- sa_out_i  in  NUM_COLS  sense-amp outputs (from SA_OUT).
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset nrst is asynchronous and active-low.
- Reset:
  - FSM is forced to IDLE immediately, asynchronously.
  - All analog controls, rd_valid_o and rd_data_o are 0; busy_o is 0.
  - rq_ready_o is 1 once in IDLE.
  - Reset mid-access drops WL/PCH/WRITE/SAEN at once; the request is lost and no rd_valid_o pulse occurs.
- Handshake:
  - rq_ready_o = (state == IDLE), driven combinationally from registered state.
  - A request is accepted on a clock edge where rq_valid_i && rq_ready_o.
  - On acceptance, register addr_i, rq_wr_i, wr_data_i, and both cfg fields.
  - Later changes to inputs or cfg do not affect the access in flight.
  - rq_valid_i while not ready is ignored; the master holds it until accepted.
- Effective lengths: P = max(cfg_pch_cycles_i, 1); W = max(cfg_wl_cycles_i, 1).
- FSM:
  - IDLE -> PCH on acceptance.
  - PCH: pch_o = 1 for P cycles, then -> WL.
  - WL: wl_o[addr] = 1 for W cycles.
    - Write: write_o = 1, wr_data_o = latched data, csel_o = all ones, then -> DONE.
    - Read: write_o = 0, csel_o = all ones, then -> SENSE.
  - SENSE (1 cycle): wl_o held and saen_o = 1; sa_out_i is registered into rd_data_o at the end of the cycle; -> DONE.
  - DONE (1 cycle): all analog controls 0 as recovery gap; rd_valid_o = 1 for reads only; -> IDLE.
- Outside its active states, each analog control is 0. wr_data_o is 0 except in WL of a write.
- Latency, with acceptance at edge t:
  - Read: rd_valid_o is high in cycle t+P+W+2.
  - Read: next acceptance is possible at t+P+W+3.
  - Write: next acceptance is possible at t+P+W+2.
- rd_data_o holds its value until the next read's SENSE capture; writes do not alter it.
- wl_o is never multi-hot. pch_o is never high together with wl_o or saen_o.
- Out-of-range address (addr >= NUM_ROWS):
  - The request is accepted and the full timing sequence runs, but wl_o stays 0.
  - A read returns rd_data_o = 0 with rd_valid_o pulsed.
- No back-to-back pipelining: exactly one access is in flight.

Optional Feature:
- Macro: QRACC_SRAM_WMASK_EN.
- Defined:
  - Adds port wr_mask_i (in, NUM_COLS), latched at acceptance.
  - During write WL, csel_o = latched mask; unselected columns are not written.
  - Reads still use csel_o = all ones.
- Undefined: no wr_mask_i port; writes use csel_o = all ones.

Test Plan:
- Reset mid-read: assert nrst low during SENSE -> saen_o, wl_o and pch_o are 0 immediately; rq_ready_o = 1 after release; no rd_valid_o pulse.
- Write at addr 5, data 0xA5A5_1234, cfg P=2, W=2 -> pch_o high 2 cycles, then wl_o = 1<<5, write_o = 1 and wr_data_o = 0xA5A5_1234 for 2 cycles, then DONE; rq_ready_o high again 6 cycles after acceptance.
- Read at addr 5 with sa_out_i model returning 0xA5A5_1234 -> saen_o high 1 cycle, rd_valid_o pulses in cycle t+6, rd_data_o = 0xA5A5_1234 and holds after the pulse.
- cfg P=0, W=0 -> both treated as 1; read rd_valid_o at t+4. Changing cfg to P=7 mid-access does not alter the in-flight timing.
- addr = 127 (last row) and, with NUM_ROWS = 100, addr = 100 -> wl_o[127] asserted in the first case; in the second, wl_o stays 0 and rd_data_o = 0.
- With QRACC_SRAM_WMASK_EN: write with mask 0x0000_FFFF -> csel_o = 0x0000_FFFF during WL. A following read still shows csel_o = 0xFFFF_FFFF.
